// File: rtl/spi_rx_ctrl.sv
// SPI mode-0 slave receive front end: synchronises the pins, drives shift_enable/serial_in for the
// downstream shift register and pulses word_done per NUM_BITS-bit word. Option: SPI_RX_FRAME_ERR_EN.
`timescale 1ns / 1ps

module spi_rx_ctrl #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sck,
  input  logic mosi,
  input  logic ss_n,
  output logic shift_enable,
  output logic serial_in,
  output logic word_done,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BITS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic            r_sck_meta, r_sck_sync, r_sck_prev;
  logic            r_mosi_meta, r_mosi_sync;
  logic            r_ss_meta, r_ss_sync;
  logic            w_rise;

  logic [1:0]      r_state, w_state_d;
  logic [CntW-1:0] r_bit_cnt, w_bit_cnt_d;
  logic            r_shift_enable, w_shift_enable_d;
  logic            r_serial_in, w_serial_in_d;
  logic            r_word_done;
  logic            r_busy;

  // Idle levels: sck low, mosi high, slave deselected.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_mosi_meta <= 1'b1;
      r_mosi_sync <= 1'b1;
      r_ss_meta   <= 1'b1;
      r_ss_sync   <= 1'b1;
    end else begin
      r_sck_meta  <= sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
      r_ss_meta   <= ss_n;
      r_ss_sync   <= r_ss_meta;
    end
  end

  assign w_rise = r_sck_sync & ~r_sck_prev;

  always_comb begin
    w_state_d        = r_state;
    w_bit_cnt_d      = r_bit_cnt;
    w_shift_enable_d = 1'b0;
    w_serial_in_d    = r_serial_in;
    case (r_state)
      StIdle: begin
        w_bit_cnt_d = '0;
        if (!r_ss_sync) begin
          w_state_d = StRecv;
        end
      end
      StRecv: begin
        // Deselect takes priority over a coincident sck edge.
        if (r_ss_sync) begin
          w_state_d   = StIdle;
          w_bit_cnt_d = '0;
        end else if (w_rise) begin
          w_shift_enable_d = 1'b1;
          w_serial_in_d    = r_mosi_sync;
          if (r_bit_cnt == LastCnt) begin
            w_bit_cnt_d = '0;
            w_state_d   = StDone;
          end else begin
            w_bit_cnt_d = r_bit_cnt + CntW'(1);
          end
        end
      end
      StDone: begin
        if (r_ss_sync) begin
          w_state_d   = StIdle;
          w_bit_cnt_d = '0;
        end else begin
          w_state_d = StRecv;
          // First bit of the next word may arrive here; keep it.
          if (w_rise) begin
            w_shift_enable_d = 1'b1;
            w_serial_in_d    = r_mosi_sync;
            w_bit_cnt_d      = CntW'(1);
          end
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= StIdle;
      r_bit_cnt      <= '0;
      r_shift_enable <= 1'b0;
      r_serial_in    <= 1'b1;
      r_word_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_bit_cnt      <= w_bit_cnt_d;
      r_shift_enable <= w_shift_enable_d;
      r_serial_in    <= w_serial_in_d;
      // One cycle after the last shift, so the shift register has already updated.
      r_word_done    <= (r_state == StDone);
      r_busy         <= (w_state_d != StIdle);
    end
  end

  assign shift_enable = r_shift_enable;
  assign serial_in    = r_serial_in;
  assign word_done    = r_word_done;
  assign busy         = r_busy;

`ifdef SPI_RX_FRAME_ERR_EN
  logic r_frame_err;
  logic w_frame_err_d;

  assign w_frame_err_d = (r_state == StRecv) && r_ss_sync && (r_bit_cnt != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_d;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Self-checking bench for spi_rx_ctrl: randomised SPI frames against a word-level reference model.
`timescale 1ns / 1ps

module tb_spi_rx_ctrl;

  localparam int unsigned NumBits = 8;
`ifdef SPI_RX_FRAME_ERR_EN
  localparam int FeEn = 1;
`else
  localparam int FeEn = 0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic n_rst, sck, mosi, ss_n;
  logic shift_enable, serial_in, word_done, busy, frame_err;

  always #5 clk = ~clk;

  spi_rx_ctrl #(.NUM_BITS(NumBits)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .sck         (sck),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .shift_enable(shift_enable),
    .serial_in   (serial_in),
    .word_done   (word_done),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_n     = 0;
  int se_cyc[$];
  int wd_cyc[$];
  logic bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Sample on the falling edge, then let the caller change inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (shift_enable === 1'b1) begin
      se_cyc.push_back(cyc);
      bits.push_back(serial_in);
    end
    if (word_done === 1'b1) wd_cyc.push_back(cyc);
    if (frame_err === 1'b1) fe_n++;
  endtask

  task automatic clear_log();
    se_cyc.delete();
    wd_cyc.delete();
    bits.delete();
    fe_n = 0;
  endtask

  task automatic send_bit(input logic b);
    int lo, hi;
    lo   = $urandom_range(3, 6);
    hi   = $urandom_range(3, 6);
    mosi = b;
    repeat (lo) tick();
    sck = 1'b1;
    repeat (hi) tick();
    sck = 1'b0;
  endtask

  task automatic send_words(input byte_q_t w);
    foreach (w[k]) begin
      for (int i = 7; i >= 0; i--) send_bit(w[k][i]);
    end
    repeat (4) tick();
  endtask

  task automatic select();
    ss_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic deselect();
    ss_n = 1'b1;
    repeat (5) tick();
  endtask

  // Downstream shift register model: MSB-first words, word_done one clk after the 8th shift.
  task automatic check_words(input string tag, input byte_q_t w);
    logic [7:0] got;
    chk({tag, " shifts"}, se_cyc.size(), 8 * w.size());
    chk({tag, " word_done count"}, wd_cyc.size(), w.size());
    foreach (w[k]) begin
      if (bits.size() >= 8 * (k + 1)) begin
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[6:0], bits[8 * k + i]};
        chk({tag, " parallel_out"}, got, w[k]);
      end
      if (wd_cyc.size() > k && se_cyc.size() >= 8 * (k + 1)) begin
        chk({tag, " word_done timing"}, wd_cyc[k], se_cyc[8 * k + 7] + 1);
      end
    end
  endtask

  initial begin
    byte_q_t words;
    int      rc;
    int      nw;

    sck   = 1'b0;
    mosi  = 1'b1;
    ss_n  = 1'b1;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #2;
    chk("reset shift_enable", shift_enable, 0);
    chk("reset serial_in", serial_in, 1);
    chk("reset word_done", word_done, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_err", frame_err, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (2) tick();
    chk("idle busy", busy, 0);

    // Latency of a single sck rise, then abort a 1-bit partial frame.
    select();
    chk("select busy", busy, 1);
    clear_log();
    mosi = 1'b1;
    repeat (4) tick();
    rc  = cyc;
    sck = 1'b1;
    repeat (5) tick();
    chk("latency pulse count", se_cyc.size(), 1);
    if (se_cyc.size() > 0) begin
      chk("latency edges", se_cyc[0] - rc, 3);
      chk("latency serial_in", bits[0], 1);
    end
    sck = 1'b0;
    repeat (4) tick();
    deselect();
    chk("partial deselect busy", busy, 0);
    chk("partial frame_err", fe_n, FeEn);

    // Single word 0xA5.
    select();
    clear_log();
    words = '{8'hA5};
    send_words(words);
    check_words("A5", words);
    deselect();
    chk("A5 frame_err", fe_n, 0);

    // Back-to-back 0x3C, 0xC3.
    select();
    clear_log();
    words = '{8'h3C, 8'hC3};
    send_words(words);
    check_words("3C_C3", words);
    deselect();

    // Abort after 5 bits.
    select();
    clear_log();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (2) tick();
    ss_n = 1'b1;
    tick();
    tick();
    chk("abort busy still high", busy, 1);
    tick();
    chk("abort busy low", busy, 0);
    repeat (3) tick();
    chk("abort shifts", se_cyc.size(), 5);
    chk("abort word_done", wd_cyc.size(), 0);
    chk("abort frame_err", fe_n, FeEn);
    select();
    clear_log();
    words = '{8'hFF};
    send_words(words);
    check_words("FF after abort", words);
    deselect();

    // Deselect coinciding with an sck rise.
    select();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    clear_log();
    mosi = 1'b1;
    repeat (4) tick();
    sck  = 1'b1;
    ss_n = 1'b1;
    repeat (6) tick();
    chk("race shifts", se_cyc.size(), 0);
    chk("race frame_err", fe_n, FeEn);
    chk("race busy", busy, 0);
    sck = 1'b0;
    repeat (3) tick();
    select();
    clear_log();
    words = '{8'($urandom_range(0, 255))};
    send_words(words);
    check_words("after race", words);
    deselect();

    // Randomised multi-word frames.
    for (int f = 0; f < 6; f++) begin
      words.delete();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) words.push_back(8'($urandom_range(0, 255)));
      select();
      clear_log();
      send_words(words);
      check_words($sformatf("random frame %0d", f), words);
      deselect();
      chk($sformatf("random frame %0d frame_err", f), fe_n, 0);
    end

    // Asynchronous reset while a shift pulse is high.
    select();
    clear_log();
    mosi = 1'b0;
    repeat (4) tick();
    sck = 1'b1;
    repeat (3) tick();
    chk("pre-reset shift_enable", shift_enable, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid reset shift_enable", shift_enable, 0);
    chk("mid reset serial_in", serial_in, 1);
    chk("mid reset word_done", word_done, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset frame_err", frame_err, 0);
    sck = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (4) tick();
    chk("post reset busy", busy, 1);
    clear_log();
    words = '{8'($urandom_range(0, 255))};
    send_words(words);
    check_words("after reset", words);
    deselect();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
